// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark pixel scheduler.
// FSM state encoding and APB register map.
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_P  = 3'd1,
    RD_W  = 3'd2,
    CAPT  = 3'd3,
    ISSUE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int CTRL       = 0;
  localparam int WHITE      = 1;
  localparam int NP         = 2;
  localparam int NW         = 3;
  localparam int PARAM_BASE = 4;
  localparam int IMG_BASE   = 10;
  localparam int NUM_PARAMS = 6;

endpackage

// File: rtl/wm_addr_gen.sv
// Pixel position counters (r, c, wr, wc) and the primary /
// watermark read-address arithmetic, truncated to address width.
module wm_addr_gen #(
  parameter int Amba_Addr_Depth = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Amba_Addr_Depth-1:0] np,
  input  logic [Amba_Addr_Depth-1:0] nw,
  input  logic                       clear,
  input  logic                       advance,
  output logic [Amba_Addr_Depth-1:0] prim_addr,
  output logic [Amba_Addr_Depth-1:0] wm_addr,
  output logic                       last
);

  localparam int AW = Amba_Addr_Depth;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] r;
  logic [AW-1:0] c;
  logic [AW-1:0] wr;
  logic [AW-1:0] wc;
  logic          c_end;
  logic          wc_end;
  logic          wr_end;

  assign c_end  = (c == np - ONE);
  assign wc_end = (nw == '0) || (wc == nw - ONE);
  assign wr_end = (nw == '0) || (wr == nw - ONE);
  assign last   = c_end && (r == np - ONE);

  // Products kept at address width; overflow wraps silently.
  assign prim_addr = r * np + c;
  assign wm_addr   = np * np + wr * nw + wc;

  // Raster-order stepping; the watermark tiles across the image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r  <= '0;
      c  <= '0;
      wr <= '0;
      wc <= '0;
    end else if (clear) begin
      r  <= '0;
      c  <= '0;
      wr <= '0;
      wc <= '0;
    end else if (advance) begin
      if (c_end) begin
        c  <= '0;
        r  <= r + ONE;
        wc <= '0;
        wr <= wr_end ? '0 : wr + ONE;
      end else begin
        c  <= c + ONE;
        wc <= wc_end ? '0 : wc + ONE;
      end
    end
  end

endmodule

// File: rtl/wm_scheduler.sv
// APB-programmed scheduler feeding primary/watermark pixel pairs to a datapath.
// Optional cycle_cnt perf counter port: define WM_SCHED_PERF_EN.
module wm_scheduler
  import wm_pkg::*;
#(
  parameter int Amba_Addr_Depth = 20,
  parameter int Amba_Word       = 16,
  parameter int Data_Depth      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [Amba_Addr_Depth-1:0]       PADDR,
  input  logic [Amba_Word-1:0]             PWDATA,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [Amba_Addr_Depth-1:0]       mem_addr,
  output logic [Data_Depth-1:0]            mem_wdata,
  input  logic [Data_Depth-1:0]            mem_rdata,
  output logic                             dp_valid,
  input  logic                             dp_ready,
  output logic [Data_Depth-1:0]            dp_prim,
  output logic [Data_Depth-1:0]            dp_wm,
  output logic [Data_Depth-1:0]            dp_white,
  output logic [NUM_PARAMS*Data_Depth-1:0] dp_param,
  output logic                             busy,
  output logic                             Image_Done
`ifdef WM_SCHED_PERF_EN
  ,
  output logic [31:0]                      cycle_cnt
`endif
);

  localparam int AW = Amba_Addr_Depth;
  localparam int DD = Data_Depth;

  state_t state;
  state_t state_nxt;

  logic                     apb_wr;
  logic                     idle;
  logic                     reg_hit;
  logic                     reg_wr;
  logic                     img_wr;
  logic                     start_wr;
  logic                     go;
  logic                     advance;
  logic                     np_zero;
  logic                     nw_zero;
  logic                     last;

  logic                     ctrl_q;
  logic [DD-1:0]            white_q;
  logic [AW-1:0]            np_q;
  logic [AW-1:0]            nw_q;
  logic [NUM_PARAMS*DD-1:0] param_q;
  logic [DD-1:0]            prim_q;
  logic [DD-1:0]            wm_q;
  logic [AW-1:0]            prim_addr;
  logic [AW-1:0]            wm_addr;

  logic                     en_c;
  logic                     we_c;
  logic [AW-1:0]            addr_c;
  logic [DD-1:0]            wdata_c;

  assign apb_wr   = PSEL & PENABLE & PWRITE;
  assign idle     = (state == IDLE);
  assign reg_hit  = (PADDR < AW'(IMG_BASE));
  assign reg_wr   = idle & apb_wr & reg_hit;
  assign img_wr   = idle & apb_wr & ~reg_hit;
  assign start_wr = reg_wr & (PADDR == AW'(CTRL)) & PWDATA[0];
  assign go       = idle & (ctrl_q | start_wr);
  assign advance  = (state == ISSUE) & dp_ready;
  assign np_zero  = (np_q == '0);
  assign nw_zero  = (nw_q == '0);

  wm_addr_gen #(
    .Amba_Addr_Depth(AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .np       (np_q),
    .nw       (nw_q),
    .clear    (go),
    .advance  (advance),
    .prim_addr(prim_addr),
    .wm_addr  (wm_addr),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: four cycles per pixel, stalled in ISSUE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = RD_P;
      RD_P:    state_nxt = np_zero ? DONE : RD_W;
      RD_W:    state_nxt = CAPT;
      CAPT:    state_nxt = ISSUE;
      ISSUE:   if (dp_ready) state_nxt = last ? DONE : RD_P;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port owner: APB pass-through when idle, reads when busy.
  always_comb begin
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    unique case (state)
      IDLE: begin
        if (img_wr) begin
          en_c    = 1'b1;
          we_c    = 1'b1;
          addr_c  = PADDR - AW'(IMG_BASE);
          wdata_c = PWDATA[DD-1:0];
        end
      end
      RD_P: begin
        if (!np_zero) begin
          en_c   = 1'b1;
          addr_c = prim_addr;
        end
      end
      RD_W: begin
        if (!nw_zero) begin
          en_c   = 1'b1;
          addr_c = wm_addr;
        end
      end
      default: ;
    endcase
  end

  // Outputs forced low while reset is held, even with APB active.
  always_comb begin
    mem_en     = en_c & rst;
    mem_we     = we_c & rst;
    mem_addr   = rst ? addr_c : '0;
    mem_wdata  = rst ? wdata_c : '0;
    dp_valid   = (state == ISSUE);
    busy       = (state != IDLE);
    Image_Done = (state == DONE);
  end

  assign dp_prim  = prim_q;
  assign dp_wm    = wm_q;
  assign dp_white = white_q;
  assign dp_param = param_q;

  // Register file: writable only while idle; DONE drops the start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= 1'b0;
      white_q <= '0;
      np_q    <= '0;
      nw_q    <= '0;
      param_q <= '0;
    end else if (state == DONE) begin
      ctrl_q <= 1'b0;
    end else if (reg_wr) begin
      if (PADDR == AW'(CTRL))  ctrl_q  <= PWDATA[0];
      if (PADDR == AW'(WHITE)) white_q <= PWDATA[DD-1:0];
      if (PADDR == AW'(NP))    np_q    <= AW'(PWDATA);
      if (PADDR == AW'(NW))    nw_q    <= AW'(PWDATA);
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (PADDR == AW'(PARAM_BASE + i))
          param_q[i*DD +: DD] <= PWDATA[DD-1:0];
      end
    end
  end

  // Capture read data one cycle after each read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prim_q <= '0;
      wm_q   <= '0;
    end else begin
      if (state == RD_W) prim_q <= mem_rdata;
      if (state == CAPT) wm_q   <= nw_zero ? '0 : mem_rdata;
    end
  end

`ifdef WM_SCHED_PERF_EN
  logic [31:0] cnt_q;

  // Cycles spent fetching/issuing; restarts at each start, holds after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (go)
      cnt_q <= '0;
    else if (state != IDLE && state != DONE)
      cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wm_scheduler.sv
// Self-checking bench for wm_scheduler.
// Compares against a raster/tiling reference model of reads and beats.
module tb_wm_scheduler;

  localparam int AW = 20;
  localparam int WW = 16;
  localparam int DD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [WW-1:0]   PWDATA;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DD-1:0]   mem_wdata;
  logic [DD-1:0]   mem_rdata;
  logic            dp_valid;
  logic            dp_ready;
  logic [DD-1:0]   dp_prim;
  logic [DD-1:0]   dp_wm;
  logic [DD-1:0]   dp_white;
  logic [6*DD-1:0] dp_param;
  logic            busy;
  logic            Image_Done;
`ifdef WM_SCHED_PERF_EN
  logic [31:0]     cycle_cnt;
`endif

  always #5 clk = ~clk;

  wm_scheduler #(
    .Amba_Addr_Depth(AW),
    .Amba_Word      (WW),
    .Data_Depth     (DD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dp_valid  (dp_valid),
    .dp_ready  (dp_ready),
    .dp_prim   (dp_prim),
    .dp_wm     (dp_wm),
    .dp_white  (dp_white),
    .dp_param  (dp_param),
    .busy      (busy),
    .Image_Done(Image_Done)
`ifdef WM_SCHED_PERF_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Image memory: synchronous, one-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] shadow [64];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
  end

  // Observation of reads, beats, stalls and completion pulses.
  int          cyc = 0;
  logic [19:0] rd_q[$];
  logic [15:0] beat_q[$];
  int          done_cnt;
  int          done_cyc;
  int          stall_seen;
  int          stall_bad;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [7:0]  pp, pw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_en && !mem_we) rd_q.push_back(mem_addr);
      if (dp_valid && dp_ready) beat_q.push_back({dp_prim, dp_wm});
      if (dp_valid && !dp_ready) stall_seen++;
      if (pv && !pr && (!dp_valid || dp_prim != pp || dp_wm != pw))
        stall_bad++;
      if (Image_Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    pv = dp_valid;
    pr = dp_ready;
    pp = dp_prim;
    pw = dp_wm;
  end

  int wcyc;

  task automatic apb_wr(input int a, input int d);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = AW'(a); PWDATA = WW'(d);
    @(posedge clk); #1;
    PENABLE = 1'b1;
    wcyc = cyc;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Reference: raster scan, watermark tiled by modulo, stored after image.
  logic [19:0] exp_rd[$];
  logic [15:0] exp_beat[$];

  task automatic build_exp(input int np, input int nw);
    int p, w;
    logic [7:0] wv;
    exp_rd.delete();
    exp_beat.delete();
    for (int r = 0; r < np; r++) begin
      for (int c = 0; c < np; c++) begin
        p = r * np + c;
        exp_rd.push_back(20'(p));
        wv = 8'h00;
        if (nw > 0) begin
          w = np * np + (r % nw) * nw + (c % nw);
          exp_rd.push_back(20'(w));
          wv = shadow[w];
        end
        exp_beat.push_back({shadow[p], wv});
      end
    end
  endtask

  logic [7:0] white_sh;

  task automatic run_img(input string nm, input int np, input int nw,
                         input int mode, input bit bw);
    int n, sc, lim, dexp;
    apb_wr(2, np);
    apb_wr(3, nw);
    build_exp(np, nw);
    rd_q.delete();
    beat_q.delete();
    done_cnt = 0; done_cyc = -1;
    stall_seen = 0; stall_bad = 0;
    dp_ready = (mode != 2);
    apb_wr(0, 1);
    sc = wcyc;
    if (bw) apb_wr(1, int'(~white_sh));
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      case (mode)
        0:       dp_ready = 1'b1;
        1:       dp_ready = 1'($urandom % 2);
        default: dp_ready = (stall_seen >= 5);
      endcase
      @(posedge clk); #1;
      n++;
    end
    dp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({nm, ".done"}, 64'(done_cnt), 64'd1);
    chk({nm, ".busy"}, 64'(busy), 64'd0);
    chk({nm, ".nrd"}, 64'(rd_q.size()), 64'(exp_rd.size()));
    lim = rd_q.size() < exp_rd.size() ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < lim; i++)
      chk({nm, ".rd"}, 64'(rd_q[i]), 64'(exp_rd[i]));
    chk({nm, ".nbeat"}, 64'(beat_q.size()), 64'(exp_beat.size()));
    lim = beat_q.size() < exp_beat.size() ? beat_q.size() : exp_beat.size();
    for (int i = 0; i < lim; i++)
      chk({nm, ".beat"}, 64'(beat_q[i]), 64'(exp_beat[i]));
    chk({nm, ".stable"}, 64'(stall_bad), 64'd0);
    if (mode != 1) begin
      dexp = (np == 0) ? 2 : 1 + 4 * np * np + (mode == 2 ? 5 : 0);
      chk({nm, ".lat"}, 64'(done_cyc - sc), 64'(dexp));
    end
    if (mode == 2) chk({nm, ".stalls"}, 64'(stall_seen), 64'd5);
`ifdef WM_SCHED_PERF_EN
    if (np > 0)
      chk({nm, ".cnt"}, 64'(cycle_cnt), 64'(4 * np * np + stall_seen));
`endif
  endtask

  int wmseq [9] = '{9, 10, 9, 11, 12, 11, 9, 10, 9};
  logic [47:0] par_sh;
  int bad;

  initial begin
    rst = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; dp_ready = 1'b0;
    done_cnt = 0; stall_seen = 0; stall_bad = 0; done_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(dp_valid), 64'd0);
    chk("rst.mem_en", 64'(mem_en), 64'd0);
    chk("rst.done", 64'(Image_Done), 64'd0);
    chk("rst.white", 64'(dp_white), 64'd0);
    chk("rst.param", 64'(dp_param), 64'd0);
    chk("rst.prim", 64'(dp_prim), 64'd0);
    rst = 1'b1;

    white_sh = 8'($urandom);
    apb_wr(1, int'(white_sh));
    for (int i = 0; i < 6; i++) begin
      par_sh[i*8 +: 8] = 8'($urandom);
      apb_wr(4 + i, int'(par_sh[i*8 +: 8]));
    end
    chk("reg.white", 64'(dp_white), 64'(white_sh));
    chk("reg.param", 64'(dp_param), 64'(par_sh));

    for (int i = 0; i < 64; i++) begin
      int d;
      d = int'($urandom_range(0, 65535));
      shadow[i] = 8'(d);
      apb_wr(10 + i, d);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== shadow[i]) bad++;
    chk("memfill", 64'(bad), 64'd0);

    run_img("np2nw1", 2, 1, 0, 1'b0);
    run_img("np3nw2", 3, 2, 0, 1'b0);
    chk("wmseq.n", 64'(rd_q.size()), 64'd18);
    if (rd_q.size() == 18)
      for (int i = 0; i < 9; i++)
        chk("wmseq", 64'(rd_q[2*i+1]), 64'(wmseq[i]));
    run_img("np0", 0, 3, 0, 1'b0);
    run_img("stall", 2, 2, 2, 1'b0);
    run_img("busywr", 2, 1, 0, 1'b1);
    chk("busywr.white", 64'(dp_white), 64'(white_sh));
    run_img("nw0", 3, 0, 0, 1'b0);
    run_img("nwgt", 2, 5, 0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_img("rand", int'($urandom_range(1, 4)),
              int'($urandom_range(0, 5)), 1, 1'b0);

    apb_wr(2, 3);
    apb_wr(3, 2);
    done_cnt = 0;
    dp_ready = 1'b1;
    apb_wr(0, 1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.valid", 64'(dp_valid), 64'd0);
    chk("arst.mem_en", 64'(mem_en), 64'd0);
    chk("arst.done", 64'(Image_Done), 64'd0);
    chk("arst.white", 64'(dp_white), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("arst.idle", 64'(busy), 64'd0);
    chk("arst.nodone", 64'(done_cnt), 64'd0);
    white_sh = 8'h3C;
    apb_wr(1, int'(white_sh));
    run_img("restart", 2, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
